count_sequence_checker: RTL and testbench
=========================================

# count_sequence_checker

Sink-side companion to the 4-bit counter register: samples the counter's `cr_data_output` bus on qualified cycles and verifies that consecutive samples advance by exactly +1 modulo 2^WIDTH. It acquires lock after a run of correct increments, flags every broken step with a one-cycle pulse, and keeps a saturating error tally. It sits beside the counter in the datapath, or in benches as a self-checking monitor, with its input wired directly to the counter output.

## Interface
- `WIDTH`, default 4: width of the monitored count bus.
- `ERR_WIDTH`, default 8: width of the error counter.
- `LOCK_COUNT`, default 2: consecutive correct increments required to enter LOCKED; legal range 1..15.

- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: reset, synchronous and active-high.
- `cr_data_input` in WIDTH: count value under check. Connect it to the counter's `cr_data_output`.
- `cr_valid` in 1: sample qualifier. The block acts only on cycles where this is high.
- `locked` out 1: high while the FSM is in LOCKED.
- `mismatch` out 1: one-cycle pulse for each bad step seen in LOCKED.
- `wrap` out 1: one-cycle pulse when LOCKED sees the step 2^WIDTH-1 -> 0.
- `expected` out WIDTH: next value the block predicts, equal to last accepted sample + 1 mod 2^WIDTH.
- `err_count` out ERR_WIDTH: count of mismatch events; saturates at all-ones.

## Operation
- Internal state:
  - FSM with states EMPTY, ACQUIRE and LOCKED.
  - `last`, WIDTH bits: last accepted sample.
  - `run`, 4 bits: current run of correct increments.
- Reset values, taking effect on the first edge with `reset`=1:
  - FSM enters EMPTY.
  - `last`, `run` and `expected` go to 0.
  - `locked`, `mismatch`, `wrap` and `err_count` go to 0.
- Reset has priority over everything, including a valid sample in the same cycle. Reset in mid-run clears the lock and the error tally.
- A step is "good" when `cr_data_input` == `last` + 1 mod 2^WIDTH. The sum is truncated to WIDTH bits, so 1111 -> 0000 is good.
- `cr_valid`=0: all state holds and `mismatch`/`wrap` are 0. This applies in every state.
- Every valid sample sets `last` to the sample and `expected` to sample + 1 mod 2^WIDTH.
- EMPTY, on a valid sample: go to ACQUIRE with `run`=0. No check is made, since there is no history.
- ACQUIRE, on a valid sample:
  - Good step: `run` increments. When `run`+1 == LOCK_COUNT, go to LOCKED.
  - Bad step: `run` = 0 and stay in ACQUIRE.
  - No mismatch pulse and no `err_count` change, because acquisition errors are not counted.
- LOCKED, on a valid sample:
  - Good step: stay in LOCKED. If `last`=all-ones and the sample is 0, pulse `wrap`.
  - Bad step: pulse `mismatch`, increment `err_count` (saturating), go to ACQUIRE with `run`=0.
  - A repeated value counts as a bad step.
  - A jump to 0 caused by the counter being reset also counts as a bad step.
- `mismatch` and `wrap` are never high in the same cycle.
- Saturation: when `err_count` is all-ones, further mismatches still pulse `mismatch` but the count holds.

## Timing
- Every output is registered and updates on the same edge that accepts the sample. All outputs are therefore visible the cycle after the sample is presented.
- `mismatch` and `wrap` are high for exactly one cycle per event. Back-to-back valid cycles can produce back-to-back pulses.
- Minimum lock latency from EMPTY is LOCK_COUNT+1 valid samples.
  - With the default LOCK_COUNT=2, `locked` rises after the 3rd valid sample.
  - Gaps in `cr_valid` stretch wall-clock latency but not sample latency.
- `locked` falls on the same edge that raises `mismatch`.
- There is no combinational path from input to output.

## Test plan
- Reset and acquire:
  - Stimulus: hold `reset`=1 for 2 cycles, then feed valid 3, 4, 5.
  - Required: all outputs are 0 during reset. `locked`=1 after the sample 5 edge, with `expected`=6 and `err_count`=0.
- Wrap-around:
  - Stimulus: while LOCKED, feed valid 14, 15, 0, 1.
  - Required: a single `wrap` pulse after the sample 0 edge, no mismatch, `locked` stays 1 and `expected`=2 at the end.
- Counter reset mid-run:
  - Stimulus: while LOCKED at 7, feed valid 0, 1, 2.
  - Required: after the sample 0 edge, `mismatch` pulses, `err_count`=1 and `locked`=0. `locked` returns to 1 after the sample 2 edge.
- Valid gaps and stall:
  - Stimulus: while LOCKED, feed 9 then `cr_valid`=0 for 5 cycles with the bus toggling to random values, then valid 10.
  - Required: no pulses during the gap, `expected` holds at 10 through it, and lock is kept.
- Repeat error and acquisition immunity:
  - Stimulus: from EMPTY, feed 4, 4, 9. Then lock on 2, 3, 4, then feed 4.
  - Required: no mismatch during acquisition. The final 4 produces a mismatch pulse and `err_count` goes 0 -> 1.
- Saturation and reset priority:
  - Stimulus: force 256 locked mismatches with ERR_WIDTH=8. Then assert `reset` in the same cycle as a valid sample.
  - Required: `err_count` stops at 255 while `mismatch` still pulses. The reset cycle clears everything and the sample is ignored, so the FSM is in EMPTY.

Source files
------------

// File: rtl/count_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_sequence_checker
// Purpose  : Sink-side monitor for a free-running counter bus. It samples the
//            bus on qualified cycles and checks that consecutive samples
//            advance by exactly +1 modulo 2^WIDTH. It acquires lock after a
//            run of good steps, pulses on each broken step while locked, and
//            keeps a saturating error tally.
// Ports    : clk           - rising-edge clock
//            reset         - synchronous, active-high reset
//            cr_data_input - count value under check
//            cr_valid      - sample qualifier
//            locked        - high while in LOCKED
//            mismatch      - one-cycle pulse per bad step seen in LOCKED
//            wrap          - one-cycle pulse on all-ones -> 0 step in LOCKED
//            expected      - predicted next value (last sample + 1)
//            err_count     - saturating count of mismatch events
// Revision : 1.0 - initial release
// ============================================================================
module count_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int ERR_WIDTH  = 8,
  parameter int LOCK_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     cr_data_input,
  input  logic                 cr_valid,
  output logic                 locked,
  output logic                 mismatch,
  output logic                 wrap,
  output logic [WIDTH-1:0]     expected,
  output logic [ERR_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam logic [4:0] c_LOCK_COUNT = 5'(LOCK_COUNT);

  state_t               r_state;
  logic [WIDTH-1:0]     r_last;
  logic [3:0]           r_run;
  logic [WIDTH-1:0]     r_expected;
  logic                 r_locked;
  logic                 r_mismatch;
  logic                 r_wrap;
  logic [ERR_WIDTH-1:0] r_err_count;

  state_t               w_state_nxt;
  logic [WIDTH-1:0]     w_last_nxt;
  logic [3:0]           w_run_nxt;
  logic [WIDTH-1:0]     w_expected_nxt;
  logic                 w_mismatch_nxt;
  logic                 w_wrap_nxt;
  logic [ERR_WIDTH-1:0] w_err_nxt;
  logic                 w_good;
  logic                 w_last_ones;
  logic                 w_run_done;

  // The +1 is truncated to WIDTH bits, so all-ones -> 0 is a good step.
  assign w_good      = (cr_data_input == WIDTH'(r_last + 1'b1));
  assign w_last_ones = (r_last == {WIDTH{1'b1}});
  // Widened compare so LOCK_COUNT up to 15 never overflows the 4-bit run.
  assign w_run_done  = (({1'b0, r_run} + 5'd1) == c_LOCK_COUNT);

  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_run_nxt      = r_run;
    w_expected_nxt = r_expected;
    w_mismatch_nxt = 1'b0;
    w_wrap_nxt     = 1'b0;
    w_err_nxt      = r_err_count;

    if (cr_valid) begin
      w_last_nxt     = cr_data_input;
      w_expected_nxt = WIDTH'(cr_data_input + 1'b1);
      case (r_state)
        S_EMPTY: begin
          // No history yet: first sample only seeds the prediction.
          w_state_nxt = S_ACQUIRE;
          w_run_nxt   = 4'd0;
        end
        S_ACQUIRE: begin
          if (w_good) begin
            w_run_nxt = r_run + 4'd1;
            if (w_run_done) begin
              w_state_nxt = S_LOCKED;
            end
          end else begin
            w_run_nxt = 4'd0;
          end
        end
        S_LOCKED: begin
          if (w_good) begin
            w_wrap_nxt = w_last_ones && (cr_data_input == '0);
          end else begin
            w_mismatch_nxt = 1'b1;
            w_state_nxt    = S_ACQUIRE;
            w_run_nxt      = 4'd0;
            if (r_err_count != {ERR_WIDTH{1'b1}}) begin
              w_err_nxt = r_err_count + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_run_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_last      <= '0;
      r_run       <= 4'd0;
      r_expected  <= '0;
      r_locked    <= 1'b0;
      r_mismatch  <= 1'b0;
      r_wrap      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_run       <= w_run_nxt;
      r_expected  <= w_expected_nxt;
      r_locked    <= (w_state_nxt == S_LOCKED);
      r_mismatch  <= w_mismatch_nxt;
      r_wrap      <= w_wrap_nxt;
      r_err_count <= w_err_nxt;
    end
  end

  assign locked    = r_locked;
  assign mismatch  = r_mismatch;
  assign wrap      = r_wrap;
  assign expected  = r_expected;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_count_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_sequence_checker
// Purpose  : Directed self-checking bench for count_sequence_checker with
//            default parameters (WIDTH=4, ERR_WIDTH=8, LOCK_COUNT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_sequence_checker;

  logic       clk;
  logic       reset;
  logic [3:0] cr_data_input;
  logic       cr_valid;
  logic       locked;
  logic       mismatch;
  logic       wrap;
  logic [3:0] expected;
  logic [7:0] err_count;

  int checks;
  int errors;

  count_sequence_checker #(
    .WIDTH     (4),
    .ERR_WIDTH (8),
    .LOCK_COUNT(2)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .cr_data_input(cr_data_input),
    .cr_valid     (cr_valid),
    .locked       (locked),
    .mismatch     (mismatch),
    .wrap         (wrap),
    .expected     (expected),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Drive one cycle of stimulus, then sample just after the active edge.
  task automatic tick(input logic rst, input logic v, input logic [3:0] d);
    @(negedge clk);
    reset         = rst;
    cr_valid      = v;
    cr_data_input = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".locked"},    int'(locked),    0);
    chk({tag, ".mismatch"},  int'(mismatch),  0);
    chk({tag, ".wrap"},      int'(wrap),      0);
    chk({tag, ".expected"},  int'(expected),  0);
    chk({tag, ".err_count"}, int'(err_count), 0);
  endtask

  initial begin
    logic [3:0] v;
    int         exp_err;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    cr_valid      = 1'b0;
    cr_data_input = 4'd0;

    // Reset and acquire
    tick(1'b1, 1'b0, 4'd0);
    chk_all_zero("rst_c1");
    tick(1'b1, 1'b1, 4'd9);
    chk_all_zero("rst_c2");
    tick(1'b0, 1'b1, 4'd3);
    chk("acq3.locked", int'(locked), 0);
    chk("acq3.expected", int'(expected), 4);
    tick(1'b0, 1'b1, 4'd4);
    chk("acq4.locked", int'(locked), 0);
    tick(1'b0, 1'b1, 4'd5);
    chk("acq5.locked", int'(locked), 1);
    chk("acq5.expected", int'(expected), 6);
    chk("acq5.err_count", int'(err_count), 0);

    // Wrap-around
    for (int i = 6; i <= 13; i++) tick(1'b0, 1'b1, 4'(i));
    chk("pre_wrap.locked", int'(locked), 1);
    tick(1'b0, 1'b1, 4'd14);
    chk("w14.wrap", int'(wrap), 0);
    tick(1'b0, 1'b1, 4'd15);
    chk("w15.wrap", int'(wrap), 0);
    tick(1'b0, 1'b1, 4'd0);
    chk("w0.wrap", int'(wrap), 1);
    chk("w0.mismatch", int'(mismatch), 0);
    chk("w0.locked", int'(locked), 1);
    tick(1'b0, 1'b1, 4'd1);
    chk("w1.wrap", int'(wrap), 0);
    chk("w1.locked", int'(locked), 1);
    chk("w1.expected", int'(expected), 2);

    // Counter reset mid-run
    for (int i = 2; i <= 7; i++) tick(1'b0, 1'b1, 4'(i));
    tick(1'b0, 1'b1, 4'd0);
    chk("cr0.mismatch", int'(mismatch), 1);
    chk("cr0.wrap", int'(wrap), 0);
    chk("cr0.err_count", int'(err_count), 1);
    chk("cr0.locked", int'(locked), 0);
    tick(1'b0, 1'b1, 4'd1);
    chk("cr1.mismatch", int'(mismatch), 0);
    chk("cr1.locked", int'(locked), 0);
    tick(1'b0, 1'b1, 4'd2);
    chk("cr2.locked", int'(locked), 1);
    chk("cr2.err_count", int'(err_count), 1);

    // Valid gaps and stall
    for (int i = 3; i <= 9; i++) tick(1'b0, 1'b1, 4'(i));
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      chk("gap.mismatch", int'(mismatch), 0);
      chk("gap.wrap", int'(wrap), 0);
      chk("gap.expected", int'(expected), 10);
      chk("gap.locked", int'(locked), 1);
    end
    tick(1'b0, 1'b1, 4'd10);
    chk("gap10.locked", int'(locked), 1);
    chk("gap10.mismatch", int'(mismatch), 0);
    chk("gap10.expected", int'(expected), 11);

    // Repeat error and acquisition immunity
    tick(1'b1, 1'b0, 4'd0);
    chk_all_zero("rst2");
    tick(1'b0, 1'b1, 4'd4);
    chk("r4a.mismatch", int'(mismatch), 0);
    tick(1'b0, 1'b1, 4'd4);
    chk("r4b.mismatch", int'(mismatch), 0);
    tick(1'b0, 1'b1, 4'd9);
    chk("r9.mismatch", int'(mismatch), 0);
    tick(1'b0, 1'b1, 4'd2);
    chk("r2.mismatch", int'(mismatch), 0);
    chk("r2.locked", int'(locked), 0);
    tick(1'b0, 1'b1, 4'd3);
    chk("r3.locked", int'(locked), 0);
    tick(1'b0, 1'b1, 4'd4);
    chk("r4.locked", int'(locked), 1);
    chk("r4.err_count", int'(err_count), 0);
    tick(1'b0, 1'b1, 4'd4);
    chk("rep.mismatch", int'(mismatch), 1);
    chk("rep.err_count", int'(err_count), 1);
    chk("rep.locked", int'(locked), 0);

    // Saturation: relock with two good steps, then repeat the value
    exp_err = 1;
    v       = 4'd4;
    for (int i = 0; i < 256; i++) begin
      v = v + 4'd1;
      tick(1'b0, 1'b1, v);
      v = v + 4'd1;
      tick(1'b0, 1'b1, v);
      chk("sat.relock", int'(locked), 1);
      tick(1'b0, 1'b1, v);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      chk("sat.mismatch", int'(mismatch), 1);
      chk("sat.err_count", int'(err_count), exp_err);
    end
    chk("sat.final", int'(err_count), 255);

    // Reset priority over a valid sample
    tick(1'b1, 1'b1, 4'd5);
    chk_all_zero("rstp");
    tick(1'b0, 1'b1, 4'd6);
    chk("rp6.locked", int'(locked), 0);
    chk("rp6.expected", int'(expected), 7);
    tick(1'b0, 1'b1, 4'd7);
    chk("rp7.locked", int'(locked), 0);
    tick(1'b0, 1'b1, 4'd8);
    chk("rp8.locked", int'(locked), 1);
    chk("rp8.err_count", int'(err_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
